// File: rtl/store_buffer_if.sv
// Bus bundle between the pipeline/memory side and the store buffer.
// The master drives store, load and drain inputs; the slave (buffer) drives the rest.
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;

  logic              drain_en;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;

  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, drain_en,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_write, mem_address,
           mem_write_data, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, drain_en,
    output st_ready, ld_hit, ld_data, ld_stall, mem_write, mem_address,
           mem_write_data, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and the data memory write port, with load address checking.
// Define STORE_BUF_FWD_EN to forward the youngest matching store to loads instead of stalling them.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Room is judged on registered occupancy only; a same-cycle drain never admits a store.
  assign push  = sb.st_valid && !full;
  assign pop   = !empty && sb.drain_en;

  assign sb.st_ready       = !full;
  assign sb.empty          = empty;
  assign sb.count          = count_q;
  assign sb.mem_write      = pop;
  assign sb.mem_address    = empty ? '0 : addr_q[rd_ptr];
  assign sb.mem_write_data = empty ? '0 : data_q[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // Head and tail indices coincide only when empty (no pop) or full (no push).
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; valid bits and count gate every read, so stale words are unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= sb.st_addr;
      data_q[wr_ptr] <= sb.st_data;
    end
  end

  logic match;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  // Walk oldest to youngest so the last hit seen is the youngest matching store.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    match = 1'b0;
`ifdef STORE_BUF_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == sb.ld_addr)) begin
        match = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_data = data_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign sb.ld_hit   = sb.ld_valid && match;
  assign sb.ld_data  = (sb.ld_valid && match) ? match_data : '0;
  assign sb.ld_stall = 1'b0;
`else
  assign sb.ld_hit   = 1'b0;
  assign sb.ld_data  = '0;
  assign sb.ld_stall = sb.ld_valid && match;
`endif
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the EX/MEM pipeline register and the data memory write port.
- Accepts store requests from the pipeline at one per cycle and retires the oldest entry into data memory at one per cycle when allowed.
- Lets pipeline stores complete without waiting on the memory write.
- Checks every load address against the buffered stores so a load never reads stale memory.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, ≥2.
- ADDR_W, 32, address width; matches the data memory address port.
- DATA_W, 32, data width; matches the data memory data port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request this cycle.
- st_addr  input  ADDR_W  store word address.
- st_data  input  DATA_W  store data.
- st_ready  output  1  buffer can accept a store; equals !full.
- ld_valid  input  1  load in MEM stage this cycle.
- ld_addr  input  ADDR_W  load word address.
- ld_hit  output  1  a buffered store matches ld_addr (forwarding build only).
- ld_data  output  DATA_W  forwarded data from the youngest matching entry.
- ld_stall  output  1  load must stall: a matching entry exists and forwarding is compiled out.
- drain_en  input  1  memory write port available this cycle.
- mem_write  output  1  write strobe to data memory.
- mem_address  output  ADDR_W  head entry address.
- mem_write_data  output  DATA_W  head entry data.
- count  output  $clog2(DEPTH)+1  current occupancy.
- empty  output  1  count==0.

Behaviour:
- Storage: circular array with head (rd_ptr), tail (wr_ptr) and count registers. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (synchronous): rd_ptr=0, wr_ptr=0, count=0, all valid bits cleared. Outputs then read:
  - st_ready=1, empty=1
  - mem_write=0, ld_hit=0, ld_stall=0
  - ld_data=0, mem_address=0, mem_write_data=0
- Reset takes priority over a simultaneous push or pop; buffered entries are discarded.
- Push: st_valid && st_ready at posedge writes the tail entry, sets its valid bit and advances wr_ptr.
- A store with st_valid=1 while full is ignored. The pipeline must hold it until st_ready=1.
- st_ready depends only on the registered full state; a same-cycle pop does not make room.
- Drain (combinational): mem_write = !empty && drain_en.
  - mem_address and mem_write_data show the head entry whenever !empty, and 0 when empty.
  - Data memory captures the write at the falling edge of the same cycle.
- Pop: at posedge with mem_write=1, clear the head valid bit and advance rd_ptr. Drain latency is one cycle per entry.
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed whenever !full, including when count==1.
- Push into an empty buffer: the entry is visible on mem_* the following cycle (no same-cycle bypass).
- count update: +1 on push only, -1 on pop only, unchanged otherwise. count never exceeds DEPTH and never goes below 0.
- Address match: compare ld_addr against all valid entries (full ADDR_W compare).
  - Youngest match: the entry nearest wr_ptr-1 searching backwards.
  - An entry popping in the current cycle still counts as a match that cycle.
  - A store being pushed in the same cycle is not matched.
  - With ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
- Store order to memory is strict FIFO. Duplicate addresses are retained and written in order (no merging).

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined:
  - ld_hit=1 and ld_data = youngest matching entry data when ld_valid and a match exists.
  - ld_stall is tied to 0.
- Undefined:
  - ld_hit=0 and ld_data=0 constant.
  - ld_stall=1 while ld_valid and any valid entry matches.
  - The pipeline holds the load until the matching entries drain.

Test Plan:
- Reset, then st_valid=0 and drain_en=0 for 3 cycles → count=0, empty=1, st_ready=1, mem_write=0.
- drain_en=0; push (0x04,0x11), (0x08,0x22), (0x0C,0x33), (0x10,0x44) → count=4, st_ready=0. Fifth push (0x14,0x55) is ignored. Then drain_en=1 → mem_address/mem_write_data go 0x04/0x11, 0x08/0x22, 0x0C/0x33, 0x10/0x44 on four consecutive cycles, then empty=1.
- count=2, drain_en=1, st_valid=1 on every cycle for 6 cycles → count stays 2; pointers wrap past DEPTH-1; writes emerge in push order.
- Push (0x20,0xAA) then (0x20,0xBB), drain_en=0, ld_valid=1, ld_addr=0x20:
  - With STORE_BUF_FWD_EN → ld_hit=1, ld_data=0xBB, ld_stall=0.
  - Without → ld_stall=1 until both entries drain, then 0.
- ld_addr=0x24 with only 0x20 entries buffered → ld_hit=0, ld_stall=0.
- Three entries buffered, reset asserted for one cycle concurrently with st_valid=1 and drain_en=1 → next cycle count=0, mem_write=0, and no write of the pushed store ever appears.
